deco_exe_pipe_reg: RTL and testbench

//  Decode->execute pipeline register with a 2-entry skid buffer.

---
 rtl/deco_exe_pipe_reg_pkg.sv | 49 ++++
 rtl/deco_exe_pipe_reg.sv | 170 +++++++++++++++++
 tb/tb_deco_exe_pipe_reg.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/deco_exe_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deco_exe_pipe_reg_pkg
// Description : Shared types for the decode->execute pipeline register:
//               control-unit bundle, the NOP control constant, the held
//               payload record and the skid-buffer occupancy states.
// Revision    : 1.0 - initial release
// ============================================================================
package deco_exe_pipe_reg_pkg;

  // Payload field widths. The pipeline register's DATA_W / REG_ADDR_W
  // parameters default to these and must be kept equal to them.
  localparam int unsigned DE_DATA_W     = 32;
  localparam int unsigned DE_REG_ADDR_W = 4;

  // Control bundle produced by the control unit for one instruction.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } deco_exe_cu_signals;

  // Bubble control: every control bit inactive, so execute does nothing.
  localparam deco_exe_cu_signals CU_NOP = '0;

  // One beat as held in either the main or the skid entry.
  typedef struct packed {
    deco_exe_cu_signals         ctr;
    logic [DE_DATA_W-1:0]       op_a;
    logic [DE_DATA_W-1:0]       op_b;
    logic [DE_REG_ADDR_W-1:0]   rd;
    logic [DE_DATA_W-1:0]       pc;
    logic                       blink;
  } deco_exe_payload_t;

  // Occupancy of the two-entry buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } de_state_t;

endpackage
`default_nettype wire

// File: rtl/deco_exe_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : deco_exe_pipe_reg
// Description : Decode->execute pipeline register with a 2-entry skid buffer.
//               The main entry drives the execute-side outputs; the skid
//               entry absorbs the beat accepted while execute stalls, so
//               in_ready depends on registered state only. A flush from
//               execute drops everything held and the beat offered that cycle.
// Ports       : clk, rst_n (async, active-low)
//               in_*      : decode-side beat + valid/ready handshake
//               out_*     : execute-side beat + valid/ready handshake
//               flush     : branch taken in execute, kill all work
//               stall_cnt : saturating count of out_valid & !out_ready cycles
// Revision    : 1.0 - initial release
// ============================================================================
module deco_exe_pipe_reg
  import deco_exe_pipe_reg_pkg::*;
#(
  parameter int unsigned DATA_W     = DE_DATA_W,
  parameter int unsigned REG_ADDR_W = DE_REG_ADDR_W,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // decode side
  input  logic                  in_valid,
  output logic                  in_ready,
  input  deco_exe_cu_signals    in_ctr,
  input  logic [DATA_W-1:0]     in_op_a,
  input  logic [DATA_W-1:0]     in_op_b,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic                  in_blink,
  // execute side
  output logic                  out_valid,
  input  logic                  out_ready,
  output deco_exe_cu_signals    out_ctr,
  output logic [DATA_W-1:0]     out_op_a,
  output logic [DATA_W-1:0]     out_op_b,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [DATA_W-1:0]     out_pc,
  output logic                  out_blink,
  // control / status
  input  logic                  flush,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  de_state_t         r_state;
  de_state_t         w_state_nxt;
  deco_exe_payload_t r_main;
  deco_exe_payload_t r_skid;
  deco_exe_payload_t w_in_beat;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_acc;
  logic w_take;
  logic w_load_main;
  logic w_load_skid;
  logic w_skid_to_main;
  logic w_stall;

  assign w_in_beat = '{ctr:   in_ctr,
                       op_a:  in_op_a,
                       op_b:  in_op_b,
                       rd:    in_rd,
                       pc:    in_pc,
                       blink: in_blink};

  // Both handshake flags come straight from the state register, which keeps
  // out_ready out of the in_ready cone.
  assign in_ready  = (r_state != TWO);
  assign out_valid = (r_state != EMPTY);

  assign w_acc   = in_valid & in_ready;
  assign w_take  = out_valid & out_ready;
  assign w_stall = out_valid & ~out_ready & ~flush;

  // --------------------------------------------------------------------------
  // Next-state / entry-load decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;

    case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_state_nxt = ONE;
          w_load_main = 1'b1;
        end
      end
      ONE: begin
        if (w_acc && w_take) begin
          // Head leaves while the new beat arrives: replace in place.
          w_load_main = 1'b1;
        end else if (w_acc) begin
          w_state_nxt = TWO;
          w_load_skid = 1'b1;
        end else if (w_take) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain case exists.
        if (w_take) begin
          w_state_nxt    = ONE;
          w_skid_to_main = 1'b1;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase

    // Flush overrides everything; a beat accepted this cycle is discarded.
    if (flush) begin
      w_state_nxt    = EMPTY;
      w_load_main    = 1'b0;
      w_load_skid    = 1'b0;
      w_skid_to_main = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State, payload entries and stall counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_load_main) begin
        r_main <= w_in_beat;
      end else if (w_skid_to_main) begin
        r_main <= r_skid;
      end

      if (w_load_skid) begin
        r_skid <= w_in_beat;
      end

      if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: control and destination are masked to a NOP bubble when empty;
  // data and PC simply show the last main entry.
  // --------------------------------------------------------------------------
  assign out_ctr   = out_valid ? r_main.ctr : CU_NOP;
  assign out_rd    = out_valid ? r_main.rd  : '0;
  assign out_blink = out_valid & r_main.blink;
  assign out_op_a  = r_main.op_a;
  assign out_op_b  = r_main.op_b;
  assign out_pc    = r_main.pc;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_deco_exe_pipe_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_deco_exe_pipe_reg
// Description : Self-checking bench for deco_exe_pipe_reg. A queue-based
//               reference (capacity-2 FIFO with flush and a saturating stall
//               counter) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deco_exe_pipe_reg;
  import deco_exe_pipe_reg_pkg::*;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned STALL_MAX  = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  deco_exe_cu_signals    in_ctr;
  logic [DATA_W-1:0]     in_op_a;
  logic [DATA_W-1:0]     in_op_b;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0]     in_pc;
  logic                  in_blink;
  logic                  out_valid;
  logic                  out_ready;
  deco_exe_cu_signals    out_ctr;
  logic [DATA_W-1:0]     out_op_a;
  logic [DATA_W-1:0]     out_op_b;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [DATA_W-1:0]     out_pc;
  logic                  out_blink;
  logic                  flush;
  logic [CNT_W-1:0]      stall_cnt;

  always #5 clk = ~clk;

  deco_exe_pipe_reg #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctr    (in_ctr),
    .in_op_a   (in_op_a),
    .in_op_b   (in_op_b),
    .in_rd     (in_rd),
    .in_pc     (in_pc),
    .in_blink  (in_blink),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctr   (out_ctr),
    .out_op_a  (out_op_a),
    .out_op_b  (out_op_b),
    .out_rd    (out_rd),
    .out_pc    (out_pc),
    .out_blink (out_blink),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference state
  deco_exe_payload_t m_q[$];
  deco_exe_payload_t m_last;
  int unsigned       m_stall;

  // Stimulus / observation
  deco_exe_payload_t src_q[$];
  logic [31:0]       got_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic deco_exe_payload_t make_beat(input logic [31:0] pc);
    deco_exe_payload_t p;
    logic [31:0] r;
    r       = $urandom;
    p.ctr   = r[10:0];
    p.op_a  = $urandom;
    p.op_b  = $urandom;
    r       = $urandom;
    p.rd    = r[3:0];
    p.blink = r[4];
    p.pc    = pc;
    return p;
  endfunction

  task automatic apply(input deco_exe_payload_t p);
    in_ctr   = p.ctr;
    in_op_a  = p.op_a;
    in_op_b  = p.op_b;
    in_rd    = p.rd;
    in_pc    = p.pc;
    in_blink = p.blink;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last  = '0;
    m_stall = 0;
  endtask

  // One clock edge of the reference, using the inputs currently driven.
  task automatic model_step();
    deco_exe_payload_t beat;
    bit acc, take;
    int n;
    beat = '{ctr: in_ctr, op_a: in_op_a, op_b: in_op_b,
             rd: in_rd, pc: in_pc, blink: in_blink};
    n    = m_q.size();
    acc  = in_valid && (n < 2);
    take = (n > 0) && out_ready;
    if ((n > 0) && !out_ready && !flush && (m_stall < STALL_MAX)) m_stall++;
    if (flush) begin
      m_q.delete();
    end else begin
      if (take) void'(m_q.pop_front());
      if (acc)  m_q.push_back(beat);
    end
    if (m_q.size() > 0) m_last = m_q[0];
  endtask

  task automatic check_all();
    bit v;
    v = (m_q.size() > 0);
    chk("out_valid", out_valid, v);
    chk("in_ready",  in_ready,  m_q.size() < 2);
    chk("out_ctr",   out_ctr,   v ? m_last.ctr : CU_NOP);
    chk("out_rd",    out_rd,    v ? m_last.rd : '0);
    chk("out_blink", out_blink, v & m_last.blink);
    chk("out_op_a",  out_op_a,  m_last.op_a);
    chk("out_op_b",  out_op_b,  m_last.op_b);
    chk("out_pc",    out_pc,    m_last.pc);
    chk("stall_cnt", stall_cnt, m_stall);
  endtask

  task automatic step(input bit do_check);
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (do_check) check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    apply(make_beat(32'h0));
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    src_q.delete();
    got_q.delete();
    check_all();
  endtask

  // rmode: 0 = out_ready low, 1 = high, 2 = random.
  task automatic pump(input int cycles, input int rmode, input int flush_pct, input int gap_pct);
    for (int i = 0; i < cycles; i++) begin
      bit rdy;
      if ((src_q.size() > 0) && ($urandom_range(0, 99) >= gap_pct)) begin
        in_valid = 1'b1;
        apply(src_q[0]);
      end else begin
        in_valid = 1'b0;
        apply(make_beat($urandom));
      end
      out_ready = (rmode == 2) ? ($urandom_range(0, 1) == 1) : (rmode == 1);
      flush     = ($urandom_range(0, 99) < flush_pct);
      rdy       = in_ready;
      if (out_valid && out_ready) got_q.push_back(out_pc);
      step(1'b1);
      if (in_valid && rdy) void'(src_q.pop_front());
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    apply(make_beat(32'h0));
    model_reset();

    // 1: single beat, one-cycle latency
    do_reset();
    src_q.push_back(make_beat(32'h40));
    src_q[0].op_a = 32'h11;
    src_q[0].rd   = 4'd3;
    pump(1, 1, 0, 0);
    chk("t1_out_valid", out_valid, 1'b1);
    chk("t1_op_a",      out_op_a,  32'h11);
    chk("t1_rd",        out_rd,    4'd3);
    chk("t1_stall",     stall_cnt, 0);
    pump(2, 1, 0, 0);

    // 2: backpressure, C waits in decode, order preserved
    do_reset();
    for (int i = 0; i < 3; i++) src_q.push_back(make_beat(32'h100 + 4 * i));
    pump(4, 0, 0, 0);
    chk("t2_in_ready_low", in_ready, 1'b0);
    chk("t2_c_held",       src_q.size(), 1);
    chk("t2_stall",        stall_cnt, 3);
    pump(6, 1, 0, 0);
    chk("t2_count", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      chk("t2_order", got_q[i], 32'h100 + 4 * i);

    // 3: stall counting and saturation
    do_reset();
    for (int i = 0; i < 2; i++) src_q.push_back(make_beat(32'h200 + 4 * i));
    pump(6, 0, 0, 0);
    chk("t3_stall5", stall_cnt, 5);
    for (int i = 0; i < 65529; i++) step(1'b0);
    chk("t3_fffe", stall_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("t3_sat", stall_cnt, 16'hFFFF);

    // 4: flush in TWO with a beat offered
    do_reset();
    for (int i = 0; i < 2; i++) src_q.push_back(make_beat(32'h300 + 4 * i));
    pump(2, 0, 0, 0);
    apply(make_beat(32'hDEAD));
    in_valid  = 1'b1;
    out_ready = 1'b0;
    flush     = 1'b1;
    step(1'b1);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4_out_valid", out_valid, 1'b0);
    chk("t4_in_ready",  in_ready,  1'b1);
    chk("t4_ctr_nop",   out_ctr,   CU_NOP);
    got_q.delete();
    pump(5, 1, 0, 0);
    chk("t4_nothing_out", got_q.size(), 0);

    // 5: full throughput streaming
    do_reset();
    for (int i = 0; i < 8; i++) src_q.push_back(make_beat(4 * i));
    pump(9, 1, 0, 0);
    chk("t5_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      chk("t5_pc", got_q[i], 4 * i);

    // 6: asynchronous reset in TWO, observed before the next edge
    do_reset();
    for (int i = 0; i < 3; i++) src_q.push_back(make_beat(32'h500 + 4 * i));
    pump(3, 0, 0, 0);
    chk("t6_in_two", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    src_q.delete();
    check_all();

    // 7: randomized traffic with random backpressure, gaps and flushes
    do_reset();
    for (int i = 0; i < 200; i++) src_q.push_back(make_beat($urandom));
    pump(400, 2, 5, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
